// File: rtl/shift_seq_pkg.sv
// Purpose:      shared types and widths for the multi-cycle RV32 shift sequencer.
// Latency:      n/a (declarations only).
// Backpressure: n/a.
// Contents: XLEN/SHW widths, shift_op_e (op encoding), seq_state_e (sequencer FSM).
package shift_seq_pkg;

  localparam int XLEN = 32;
  localparam int SHW  = 5;

  typedef enum logic [1:0] {
    SH_SLL,
    SH_SRL,
    SH_SRA,
    SH_RSVD
  } shift_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } seq_state_e;

endpackage

// File: rtl/shift_step.sv
// Purpose:      one combinational shift step (SLL/SRL/SRA) applied to the working value.
// Latency:      combinational.
// Backpressure: none; the sequencer decides when the step is registered.
// Ports: op (operation), value (current working value), step4 (shift by 4 instead of 1,
//        present only with SHIFT_SEQ_STEP4_EN), value_nxt (value after the step).
// The reserved op passes the value through unchanged.
module shift_step
  import shift_seq_pkg::*;
(
  input  shift_op_e       op,
  input  logic [XLEN-1:0] value,
`ifdef SHIFT_SEQ_STEP4_EN
  input  logic            step4,
`endif
  output logic [XLEN-1:0] value_nxt
);

  always_comb begin
    value_nxt = value;
`ifdef SHIFT_SEQ_STEP4_EN
    if (step4) begin
      case (op)
        SH_SLL:  value_nxt = {value[XLEN-5:0], 4'b0000};
        SH_SRL:  value_nxt = {4'b0000, value[XLEN-1:4]};
        SH_SRA:  value_nxt = {{4{value[XLEN-1]}}, value[XLEN-1:4]};
        default: value_nxt = value;
      endcase
    end else begin
      case (op)
        SH_SLL:  value_nxt = {value[XLEN-2:0], 1'b0};
        SH_SRL:  value_nxt = {1'b0, value[XLEN-1:1]};
        SH_SRA:  value_nxt = {value[XLEN-1], value[XLEN-1:1]};
        default: value_nxt = value;
      endcase
    end
`else
    case (op)
      SH_SLL:  value_nxt = {value[XLEN-2:0], 1'b0};
      SH_SRL:  value_nxt = {1'b0, value[XLEN-1:1]};
      SH_SRA:  value_nxt = {value[XLEN-1], value[XLEN-1:1]};
      default: value_nxt = value;
    endcase
`endif
  end

endmodule

// File: rtl/shift_sequencer.sv
// Purpose:      multi-cycle SLL/SRL/SRA unit for the RV32 ALU, iterating a single-step shifter.
// Latency:      shamt+1 cycles from accept to valid_o (SHIFT_SEQ_STEP4_EN: shamt/4 + shamt%4 + 1).
// Backpressure: one op in flight; ready_o only in IDLE, result held in DONE until ready_i.
// Ports: clk_i/rst_ni (sync active-low reset); request valid_i/ready_o with op_i, value_i,
//        shamt_i; flush_i kills the op in flight; response valid_o/ready_i with value_o;
//        busy_o high in SHIFT or DONE.
// Optional feature macro: SHIFT_SEQ_STEP4_EN (4-bit steps while the remaining count >= 4).
module shift_sequencer
  import shift_seq_pkg::*;
(
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [1:0]      op_i,
  input  logic [XLEN-1:0] value_i,
  input  logic [SHW-1:0]  shamt_i,
  input  logic            flush_i,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [XLEN-1:0] value_o,
  output logic            busy_o
);

  seq_state_e      state_q, state_d;
  shift_op_e       op_q, op_d;
  logic [XLEN-1:0] value_q, value_d;
  logic [SHW-1:0]  count_q, count_d;
  logic [XLEN-1:0] step_val;
  logic [SHW-1:0]  dec;

`ifdef SHIFT_SEQ_STEP4_EN
  logic step4;
  assign step4 = (count_q >= SHW'(4));
  assign dec   = step4 ? SHW'(4) : SHW'(1);
`else
  assign dec   = SHW'(1);
`endif

  shift_step u_step (
    .op        (op_q),
    .value     (value_q),
`ifdef SHIFT_SEQ_STEP4_EN
    .step4     (step4),
`endif
    .value_nxt (step_val)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      op_q    <= SH_SLL;
      value_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      value_q <= value_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    value_d = value_q;
    count_d = count_q;
    case (state_q)
      S_IDLE: begin
        // flush outranks a request arriving in the same cycle
        if (valid_i && !flush_i) begin
          op_d    = shift_op_e'(op_i);
          value_d = value_i;
          if (shamt_i != '0 && shift_op_e'(op_i) != SH_RSVD) begin
            count_d = shamt_i;
            state_d = S_SHIFT;
          end else begin
            // zero shift or reserved op: result is the operand itself
            count_d = '0;
            state_d = S_DONE;
          end
        end
      end
      S_SHIFT: begin
        if (flush_i) begin
          state_d = S_IDLE;
        end else begin
          value_d = step_val;
          count_d = count_q - dec;
          if (count_d == '0) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (flush_i || ready_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // ready_o is forced low while reset is asserted so nothing is accepted then
  assign ready_o = rst_ni && (state_q == S_IDLE);
  assign valid_o = (state_q == S_DONE);
  assign busy_o  = (state_q == S_SHIFT) || (state_q == S_DONE);
  assign value_o = value_q;

endmodule
